signed_divider_seq: RTL and testbench

- Multi-cycle signed integer divider for the 8-bit ALU datapath.
- Restoring algorithm built on repeated trial subtraction; produces one quotient bit per cycle.
- Sits beside the combinational adder/subtractor as the ALU's divide unit, with a start/done handshake.
- Reports divide-by-zero and the single two's-complement overflow case.

---
 rtl/signed_divider_seq.sv | 170 +++++++++++++++++
 tb/tb_signed_divider_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider_seq.sv
// Sequential restoring signed divider: one quotient bit per clock, start/done handshake.
// Define DIVIDER_SATURATE_EN to saturate the quotient on -2^(WIDTH-1) / -1 instead of wrapping.
module signed_divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_ZERO} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             ovf_case_q, ovf_case_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH+1:0] prem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
  assign dvd_abs = dividend[WIDTH-1] ? neg(dividend) : dividend;
  assign dvs_abs = divisor[WIDTH-1]  ? neg(divisor)  : divisor;
  assign prem_sh = {prem_q, dvd_q[WIDTH-1]};
  assign trial   = prem_sh - {2'b00, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (divisor == '0) ? S_ZERO : S_DIV;
      S_DIV:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      S_ZERO:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    prem_d     = prem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    ovf_case_d = ovf_case_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d      = dvd_abs;
          dvs_d      = dvs_abs;
          quo_neg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rem_neg_d  = dividend[WIDTH-1];
          ovf_case_d = (dividend == Q_MIN) && (divisor == '1);
          prem_d     = '0;
          cnt_d      = CW'(WIDTH-1);
          busy_d     = 1'b1;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
        end
      end
      S_DIV: begin
        // A borrow out of the trial subtraction means restore and shift in 0.
        dvd_d  = {dvd_q[WIDTH-2:0], ~trial[WIDTH+1]};
        prem_d = trial[WIDTH+1] ? prem_sh[WIDTH:0] : trial[WIDTH:0];
        cnt_d  = cnt_q - CW'(1);
      end
      S_FIX: begin
        quo_d  = quo_neg_q ? neg(dvd_q) : dvd_q;
        rem_d  = rem_neg_q ? neg(prem_q[WIDTH-1:0]) : prem_q[WIDTH-1:0];
        if (ovf_case_q) begin
          ovf_d = 1'b1;
`ifdef DIVIDER_SATURATE_EN
          quo_d = Q_MAX;
`else
          quo_d = Q_MIN;
`endif
        end
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      S_ZERO: begin
        quo_d  = '0;
        rem_d  = rem_neg_q ? neg(dvd_q) : dvd_q;
        dbz_d  = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      prem_q     <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      ovf_case_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      prem_q     <= prem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      ovf_case_q <= ovf_case_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_divider_seq.sv
// Randomized scoreboard bench for signed_divider_seq; expected results come from plain integer / and %.
module tb_signed_divider_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic signed [7:0] dividend;
  logic signed [7:0] divisor;
  logic              busy;
  logic              done;
  logic [7:0]        quotient;
  logic [7:0]        remainder;
  logic              div_by_zero;
  logic              overflow;

  signed_divider_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
    int         acc;
    int         a;
    int         b;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    int   q;
    int   r;
    e.acc = acc; e.a = a; e.b = b;
    e.dbz = 1'b0; e.ovf = 1'b0; e.lat = 9;
    if (b == 0) begin
      e.q = 8'd0; e.r = a[7:0]; e.dbz = 1'b1; e.lat = 1;
    end else if (a == -128 && b == -1) begin
`ifdef DIVIDER_SATURATE_EN
      e.q = 8'd127;
`else
      e.q = 8'h80;
`endif
      e.r = 8'd0; e.ovf = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      e.q = q[7:0];
      e.r = r[7:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b lat=%0d", e.a, e.b,
                 $signed(quotient), $signed(remainder), div_by_zero, overflow, edge_cnt - e.acc);
        chk("quotient",    int'(quotient),    int'(e.q));
        chk("remainder",   int'(remainder),   int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
        chk("overflow",    int'(overflow),    int'(e.ovf));
        chk("latency",     edge_cnt - e.acc,  e.lat);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  // Called at a falling edge; request is taken at the next rising edge.
  task automatic issue(input int a, input int b);
    start    = 1'b1;
    dividend = 8'(a);
    divisor  = 8'(b);
    sb.push_back(model(a, b, edge_cnt + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", int'(n >= 60), 0);
    if (n >= 60) sb.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_quotient"}, int'(quotient), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_div_by_zero"}, int'(div_by_zero), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  initial begin
    int a;
    int b;
    int sel;
    int n;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(7, 2);    wait_idle();
    issue(-7, 2);   wait_idle();
    issue(7, -2);   wait_idle();
    issue(-7, -2);  wait_idle();
    issue(-128, -1); wait_idle();
    issue(-128, 1); wait_idle();

    issue(5, 0); wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_div_by_zero", int'(div_by_zero), 1);
    chk("hold_remainder", int'(remainder), 5);
    issue(127, 127);
    chk("dbz_cleared_on_start", int'(div_by_zero), 0);
    wait_idle();

    // Second request lands while busy and must be dropped.
    issue(100, 7);
    @(negedge clk);
    start = 1'b1; dividend = 8'sd1; divisor = 8'sd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // Abort mid-operation with an asynchronous reset.
    issue(-127, -15);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("no_done_after_abort_busy", int'(busy), 0);
    issue(-127, -15); wait_idle();

    // Back-to-back: next start in the done cycle.
    issue(9, 4);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_timeout", int'(n >= 30), 0);
    issue(0, 3);
    wait_idle();

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      a = int'($signed(8'($urandom)));
      b = int'($signed(8'($urandom)));
      if (sel == 0) b = 0;
      else if (sel == 1) begin a = -128; b = -1; end
      else if (sel == 2) a = -128;
      issue(a, b);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
